wreg_dest_pipe: RTL

- Parametrised successor to the execute-stage write-register selector.
- Selects the destination register (rt, rd, or the link register) from decode-stage fields, then carries it through a configurable number of pipeline stages (E, M, W for STAGES=3), honouring per-stage stall and flush.
- Compares the carried destinations against the decode-stage source registers and emits per-stage match vectors plus a youngest-match forwarding select.
- Sits beside the datapath pipeline registers and feeds the hazard unit.

---
 rtl/wreg_dest_pipe.sv | 113 +++++++++++
 1 files changed

// File: rtl/wreg_dest_pipe.sv
// Destination-register tracker for the E..W pipeline: selects rt/rd/link at decode,
// carries it through STAGES registers with stall/flush, and reports source matches.

module wreg_dest_stage #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flushHere,
    input  logic              stallHere,
    input  logic              stallUp,
    input  logic [REG_AW-1:0] dstUp,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    output logic [REG_AW-1:0] dst,
    output logic              valid,
    output logic              matchRs,
    output logic              matchRt
);
    // Flush wins over a local stall; a free stage behind a stalled one takes a bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        dst <= '0;
        else if (flushHere) dst <= '0;
        else if (stallHere) dst <= dst;
        else if (stallUp)   dst <= '0;
        else                dst <= dstUp;
    end

    assign valid   = |dst;
    assign matchRs = valid && (dst == rsD) && (|rsD);
    assign matchRt = valid && (dst == rtD) && (|rtD);
endmodule

module wreg_dest_pipe #(
    parameter int REG_AW   = 5,
    parameter int STAGES   = 3,
    parameter int LINK_REG = 31,
    parameter int SEL_W    = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     regwrite_d,
    input  logic [1:0]               dst_mode_d,
    input  logic [REG_AW-1:0]        rs_d,
    input  logic [REG_AW-1:0]        rt_d,
    input  logic [REG_AW-1:0]        rd_d,
    input  logic [STAGES:0]          stall,
    input  logic [STAGES-1:0]        flush,
    output logic [STAGES*REG_AW-1:0] dst_q,
    output logic [STAGES-1:0]        valid_q,
    output logic [STAGES-1:0]        match_rs,
    output logic [STAGES-1:0]        match_rt,
    output logic                     fwd_rs_hit,
    output logic [SEL_W-1:0]         fwd_rs_sel,
    output logic                     fwd_rt_hit,
    output logic [SEL_W-1:0]         fwd_rt_sel
);
    typedef enum logic [1:0] {
        MODE_RT   = 2'b00,
        MODE_RD   = 2'b01,
        MODE_LINK = 2'b10,
        MODE_RSVD = 2'b11
    } dstMode_t;

    logic [REG_AW-1:0]             dstSel;
    logic [STAGES:0][REG_AW-1:0]   chain;

    // Reserved mode is silently a non-write.
    always_comb begin
        dstSel = '0;
        if (regwrite_d) begin
            case (dstMode_t'(dst_mode_d))
                MODE_RT:   dstSel = rt_d;
                MODE_RD:   dstSel = rd_d;
                MODE_LINK: dstSel = REG_AW'(LINK_REG);
                default:   dstSel = '0;
            endcase
        end
    end

    assign chain[0] = dstSel;

    for (genvar i = 0; i < STAGES; i++) begin : gStage
        wreg_dest_stage #(.REG_AW(REG_AW)) uStage (
            .clk      (clk),
            .resetn   (resetn),
            .flushHere(flush[i]),
            .stallHere(stall[i+1]),
            .stallUp  (stall[i]),
            .dstUp    (chain[i]),
            .rsD      (rs_d),
            .rtD      (rt_d),
            .dst      (chain[i+1]),
            .valid    (valid_q[i]),
            .matchRs  (match_rs[i]),
            .matchRt  (match_rt[i])
        );
    end

    assign dst_q = chain[STAGES:1];

    // Youngest producer (lowest index) holds the most recent value.
    function automatic logic [SEL_W-1:0] lowestIdx(input logic [STAGES-1:0] v);
        lowestIdx = '0;
        for (int i = STAGES - 1; i >= 0; i--)
            if (v[i]) lowestIdx = SEL_W'(i);
    endfunction

    assign fwd_rs_hit = |match_rs;
    assign fwd_rt_hit = |match_rt;
    assign fwd_rs_sel = lowestIdx(match_rs);
    assign fwd_rt_sel = lowestIdx(match_rt);
endmodule
